imm_ctrl_fsm: RTL and testbench

- Multi-cycle control sequencer for the 16-bit MIPS16-style CPU.
- Steps each instruction through FETCH / DECODE / EXEC / MEM / WB.
- Drives the 3-bit mode select of Immediate_Extend, plus PC, IR, memory and register-file strobes.
- Sits between the instruction register and the datapath; owns the only memory request port of the core.

---
 rtl/imm_ctrl_fsm.sv | 200 ++++++++++++++++++++
 tb/tb_imm_ctrl_fsm.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the 16-bit MIPS16-style core.
// Drives the Immediate_Extend mode select plus PC, IR, memory and register-file strobes.
module imm_ctrl_fsm #(
    parameter logic [2:0]  IMM_NONE = 3'd6,
    parameter int unsigned OP_W     = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [2:0]  imm_load,
    output logic        alu_src_imm,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_write,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        C_NOP,
        C_JUMP,
        C_BRANCH,
        C_ALU_IMM,
        C_ALU_REG,
        C_LOAD,
        C_STORE,
        C_ILLEGAL
    } cls_e;

    localparam logic [2:0] IMM_SHAMT3 = 3'd0;
    localparam logic [2:0] IMM_S4     = 3'd1;
    localparam logic [2:0] IMM_S5     = 3'd2;
    localparam logic [2:0] IMM_S8     = 3'd3;
    localparam logic [2:0] IMM_Z8     = 3'd4;
    localparam logic [2:0] IMM_S11    = 3'd5;

    localparam logic [OP_W-1:0] OP_NOP    = 5'b00001;
    localparam logic [OP_W-1:0] OP_B      = 5'b00010;
    localparam logic [OP_W-1:0] OP_BEQZ   = 5'b00100;
    localparam logic [OP_W-1:0] OP_BNEZ   = 5'b00101;
    localparam logic [OP_W-1:0] OP_SLL    = 5'b00110;
    localparam logic [OP_W-1:0] OP_ADDIU3 = 5'b01000;
    localparam logic [OP_W-1:0] OP_ADDIU  = 5'b01001;
    localparam logic [OP_W-1:0] OP_LI     = 5'b01101;
    localparam logic [OP_W-1:0] OP_LW     = 5'b10011;
    localparam logic [OP_W-1:0] OP_SW     = 5'b11011;
    localparam logic [OP_W-1:0] OP_RRR    = 5'b11100;

    state_e         state_q, state_d;
    cls_e           cls_q, cls_d;
    logic           bnez_q, bnez_d;
    logic [2:0]     imm_q, imm_d;
    logic           asi_q, asi_d;

    logic [OP_W-1:0] opcode;
    cls_e            dec_cls;
    logic [2:0]      dec_imm;
    logic            unused_operand_bits;

    assign opcode              = instr[15 -: OP_W];
    assign unused_operand_bits = ^instr[15-OP_W:0];

    always_comb begin
        dec_cls = C_ILLEGAL;
        dec_imm = IMM_NONE;
        case (opcode)
            OP_NOP:    dec_cls = C_NOP;
            OP_B:      begin dec_cls = C_JUMP;    dec_imm = IMM_S11;    end
            OP_BEQZ,
            OP_BNEZ:   begin dec_cls = C_BRANCH;  dec_imm = IMM_S8;     end
            OP_SLL:    begin dec_cls = C_ALU_IMM; dec_imm = IMM_SHAMT3; end
            OP_ADDIU3: begin dec_cls = C_ALU_IMM; dec_imm = IMM_S4;     end
            OP_ADDIU:  begin dec_cls = C_ALU_IMM; dec_imm = IMM_S8;     end
            OP_LI:     begin dec_cls = C_ALU_IMM; dec_imm = IMM_Z8;     end
            OP_LW:     begin dec_cls = C_LOAD;    dec_imm = IMM_S5;     end
            OP_SW:     begin dec_cls = C_STORE;   dec_imm = IMM_S5;     end
            OP_RRR:    dec_cls = C_ALU_REG;
            default:   dec_cls = C_ILLEGAL;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d   = state_q;
        cls_d     = cls_q;
        bnez_d    = bnez_q;
        imm_d     = imm_q;
        asi_d     = asi_q;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_cls == C_ILLEGAL) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else if (dec_cls == C_NOP) begin
                    state_d = S_FETCH;
                end else begin
                    // Extender mode is frozen here so it stays stable through EXEC, MEM and WB.
                    state_d = S_EXEC;
                    cls_d   = dec_cls;
                    bnez_d  = (opcode == OP_BNEZ);
                    imm_d   = dec_imm;
                    asi_d   = (dec_cls == C_ALU_IMM) || (dec_cls == C_LOAD) || (dec_cls == C_STORE);
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_JUMP: begin
                        pc_write = 1'b1;
                        pc_src   = 2'd1;
                        state_d  = S_FETCH;
                    end
                    C_BRANCH: begin
                        if (bnez_q ? !zero : zero) begin
                            pc_write = 1'b1;
                            pc_src   = 2'd1;
                        end
                        state_d = S_FETCH;
                    end
                    C_ALU_IMM, C_ALU_REG: state_d = S_WB;
                    C_LOAD, C_STORE:      state_d = S_MEM;
                    default:              state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls_q == C_STORE);
                if (mem_ready) begin
                    state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Strobes stay quiet for as long as reset is held, even though the state already reads FETCH.
        if (!rst) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_src    = 2'd0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
            cls_q   <= C_NOP;
            bnez_q  <= 1'b0;
            imm_q   <= IMM_NONE;
            asi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            bnez_q  <= bnez_d;
            imm_q   <= imm_d;
            asi_q   <= asi_d;
        end
    end

    assign imm_load    = imm_q;
    assign alu_src_imm = asi_q;
    assign state       = state_q;

endmodule

// File: tb/tb_imm_ctrl_fsm.sv
// Directed bench for imm_ctrl_fsm: per-scenario tasks compare the full output bundle every cycle
// against hand-derived vectors {state, ir_write, pc_write, pc_src, imm_load, alu_src_imm, mem_req, mem_we, reg_write, illegal}.
module tb_imm_ctrl_fsm;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic        mem_ready;
    logic        zero;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic [2:0]  imm_load;
    logic        alu_src_imm;
    logic        mem_req;
    logic        mem_we;
    logic        reg_write;
    logic        illegal;
    logic [2:0]  state;
    logic [14:0] obs;

    int tests = 0;
    int fails = 0;

    imm_ctrl_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .mem_ready   (mem_ready),
        .zero        (zero),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .imm_load    (imm_load),
        .alu_src_imm (alu_src_imm),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .reg_write   (reg_write),
        .illegal     (illegal),
        .state       (state)
    );

    assign obs = {state, ir_write, pc_write, pc_src, imm_load, alu_src_imm,
                  mem_req, mem_we, reg_write, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] ev(input logic [2:0] st, input logic irw, input logic pcw,
                                       input logic [1:0] psrc, input logic [2:0] imm, input logic asi,
                                       input logic mreq, input logic mwe, input logic rw, input logic ill);
        return {st, irw, pcw, psrc, imm, asi, mreq, mwe, rw, ill};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        mem_ready = 1'b0;
        zero      = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b0;
        instr     = 16'h4A05;
        step();
        step();
        tests++;
        if (obs !== ev(3'd0, 0, 0, 2'd0, 3'd6, 0, 0, 0, 0, 0)) begin
            fails++;
            $display("FAIL reset_hold: got %b want %b", obs, ev(3'd0, 0, 0, 2'd0, 3'd6, 0, 0, 0, 0, 0));
        end
        rst = 1'b1;
        #1;
        tests++;
        if (obs !== ev(3'd0, 1, 1, 2'd0, 3'd6, 0, 1, 0, 0, 0)) begin
            fails++;
            $display("FAIL reset_release: got %b want %b", obs, ev(3'd0, 1, 1, 2'd0, 3'd6, 0, 1, 0, 0, 0));
        end
    endtask

    task automatic test_addiu();
        logic [14:0] exp_v [5];
        bit          rdy_v [5];
        do_reset();
        instr = 16'h4A05;
        rdy_v = '{1, 1, 1, 1, 1};
        exp_v[0] = ev(3'd0, 1, 1, 2'd0, 3'd6, 0, 1, 0, 0, 0);
        exp_v[1] = ev(3'd1, 0, 0, 2'd0, 3'd6, 0, 0, 0, 0, 0);
        exp_v[2] = ev(3'd2, 0, 0, 2'd0, 3'd3, 1, 0, 0, 0, 0);
        exp_v[3] = ev(3'd4, 0, 0, 2'd0, 3'd3, 1, 0, 0, 1, 0);
        exp_v[4] = ev(3'd0, 1, 1, 2'd0, 3'd3, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy_v[i];
            #1;
            tests++;
            if (obs !== exp_v[i]) begin
                fails++;
                $display("FAIL addiu cyc%0d: got %b want %b", i, obs, exp_v[i]);
            end
            step();
        end
    endtask

    task automatic test_lw_wait();
        logic [14:0] exp_v [9];
        bit          rdy_v [9];
        do_reset();
        instr = 16'h9C82;
        rdy_v = '{1, 1, 1, 0, 0, 0, 1, 1, 0};
        exp_v[0] = ev(3'd0, 1, 1, 2'd0, 3'd6, 0, 1, 0, 0, 0);
        exp_v[1] = ev(3'd1, 0, 0, 2'd0, 3'd6, 0, 0, 0, 0, 0);
        exp_v[2] = ev(3'd2, 0, 0, 2'd0, 3'd2, 1, 0, 0, 0, 0);
        exp_v[3] = ev(3'd3, 0, 0, 2'd0, 3'd2, 1, 1, 0, 0, 0);
        exp_v[4] = exp_v[3];
        exp_v[5] = exp_v[3];
        exp_v[6] = exp_v[3];
        exp_v[7] = ev(3'd4, 0, 0, 2'd0, 3'd2, 1, 0, 0, 1, 0);
        exp_v[8] = ev(3'd0, 0, 0, 2'd0, 3'd2, 1, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            mem_ready = rdy_v[i];
            #1;
            tests++;
            if (obs !== exp_v[i]) begin
                fails++;
                $display("FAIL lw_wait cyc%0d: got %b want %b", i, obs, exp_v[i]);
            end
            step();
        end
    endtask

    task automatic test_sw();
        logic [14:0] exp_v [6];
        bit          rdy_v [6];
        do_reset();
        instr = 16'hDC82;
        rdy_v = '{0, 1, 1, 1, 1, 0};
        exp_v[0] = ev(3'd0, 0, 0, 2'd0, 3'd6, 0, 1, 0, 0, 0);
        exp_v[1] = ev(3'd0, 1, 1, 2'd0, 3'd6, 0, 1, 0, 0, 0);
        exp_v[2] = ev(3'd1, 0, 0, 2'd0, 3'd6, 0, 0, 0, 0, 0);
        exp_v[3] = ev(3'd2, 0, 0, 2'd0, 3'd2, 1, 0, 0, 0, 0);
        exp_v[4] = ev(3'd3, 0, 0, 2'd0, 3'd2, 1, 1, 1, 0, 0);
        exp_v[5] = ev(3'd0, 0, 0, 2'd0, 3'd2, 1, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy_v[i];
            #1;
            tests++;
            if (obs !== exp_v[i]) begin
                fails++;
                $display("FAIL sw cyc%0d: got %b want %b", i, obs, exp_v[i]);
            end
            step();
        end
    endtask

    task automatic test_branch();
        logic [15:0] ins_v [5];
        bit          z_v   [5];
        bit          tk_v  [5];
        logic [2:0]  imm_v [5];
        logic [14:0] e;
        ins_v = '{16'h2003, 16'h2003, 16'h2803, 16'h2803, 16'h1000};
        z_v   = '{1, 0, 0, 1, 1};
        tk_v  = '{1, 0, 1, 0, 1};
        imm_v = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd5};
        for (int i = 0; i < 5; i++) begin
            do_reset();
            instr     = ins_v[i];
            zero      = z_v[i];
            mem_ready = 1'b1;
            step();
            step();
            mem_ready = 1'b0;
            #1;
            e = ev(3'd2, 0, tk_v[i], {1'b0, tk_v[i]}, imm_v[i], 0, 0, 0, 0, 0);
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL branch_exec case%0d: got %b want %b", i, obs, e);
            end
            step();
            e = ev(3'd0, 0, 0, 2'd0, imm_v[i], 0, 1, 0, 0, 0);
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL branch_next case%0d: got %b want %b", i, obs, e);
            end
        end
    endtask

    task automatic test_illegal_nop();
        logic [15:0] ins_v [3];
        bit          ill_v [3];
        logic [14:0] e;
        ins_v = '{16'hF800, 16'h1800, 16'h0800};
        ill_v = '{1, 1, 0};
        for (int i = 0; i < 3; i++) begin
            do_reset();
            instr     = ins_v[i];
            mem_ready = 1'b1;
            step();
            mem_ready = 1'b0;
            #1;
            e = ev(3'd1, 0, 0, 2'd0, 3'd6, 0, 0, 0, 0, ill_v[i]);
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL decode_ill_nop case%0d: got %b want %b", i, obs, e);
            end
            step();
            e = ev(3'd0, 0, 0, 2'd0, 3'd6, 0, 1, 0, 0, 0);
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL after_ill_nop case%0d: got %b want %b", i, obs, e);
            end
        end
    endtask

    task automatic test_decode_sweep();
        logic [15:0] ins_v [4];
        logic [2:0]  imm_v [4];
        bit          asi_v [4];
        logic [14:0] e;
        ins_v = '{16'h3000, 16'h4000, 16'h6800, 16'hE000};
        imm_v = '{3'd0, 3'd1, 3'd4, 3'd6};
        asi_v = '{1, 1, 1, 0};
        for (int i = 0; i < 4; i++) begin
            do_reset();
            instr     = ins_v[i];
            mem_ready = 1'b1;
            step();
            step();
            mem_ready = 1'b0;
            #1;
            e = ev(3'd2, 0, 0, 2'd0, imm_v[i], asi_v[i], 0, 0, 0, 0);
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL sweep_exec case%0d: got %b want %b", i, obs, e);
            end
            step();
            e = ev(3'd4, 0, 0, 2'd0, imm_v[i], asi_v[i], 0, 0, 1, 0);
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL sweep_wb case%0d: got %b want %b", i, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [14:0] e;
        do_reset();
        instr     = 16'hDC82;
        mem_ready = 1'b1;
        step();
        step();
        mem_ready = 1'b0;
        step();
        e = ev(3'd3, 0, 0, 2'd0, 3'd2, 1, 1, 1, 0, 0);
        tests++;
        if (obs !== e) begin
            fails++;
            $display("FAIL mid_mem_pre: got %b want %b", obs, e);
        end
        rst       = 1'b0;
        mem_ready = 1'b1;
        step();
        e = ev(3'd0, 0, 0, 2'd0, 3'd6, 0, 0, 0, 0, 0);
        tests++;
        if (obs !== e) begin
            fails++;
            $display("FAIL mid_mem_reset: got %b want %b", obs, e);
        end
        rst       = 1'b1;
        mem_ready = 1'b0;
        #1;
        e = ev(3'd0, 0, 0, 2'd0, 3'd6, 0, 1, 0, 0, 0);
        tests++;
        if (obs !== e) begin
            fails++;
            $display("FAIL mid_mem_refetch: got %b want %b", obs, e);
        end
    endtask

    initial begin
        rst       = 1'b0;
        instr     = 16'h0000;
        mem_ready = 1'b0;
        zero      = 1'b0;
        test_reset();
        test_addiu();
        test_lw_wait();
        test_sw();
        test_branch();
        test_illegal_nop();
        test_decode_sweep();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
